// File: rtl/seq_mult_param_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package seq_mult_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DEF_WIDTH = 4;

  // Counter must hold 0..WIDTH, sized as ceil(log2(WIDTH+2)).
  function automatic int cnt_w(input int width);
    return $clog2(width + 2);
  endfunction
endpackage

// File: rtl/seq_mult_param_if.sv
// Request/response bundle between a multiplier client and seq_mult_param.
interface seq_mult_param_if
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();
  logic                   start;
  logic                   mode_signed;
  logic [WIDTH-1:0]       m;
  logic [WIDTH-1:0]       q;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     out;

  modport master (output start, mode_signed, m, q, input busy, done, out);
  modport slave  (input start, mode_signed, m, q, output busy, done, out);
endinterface

// File: rtl/seq_mult_param_booth_step.sv
// One radix-2 Booth iteration: add/sub/no-op, then arithmetic shift of {acc,q,q_prev}.
module booth_step #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_acc,
  input  logic [N-1:0] i_q,
  input  logic [N-1:0] i_m,
  input  logic         i_qprev,
  output logic [N-1:0] o_acc,
  output logic [N-1:0] o_q,
  output logic         o_qprev
);
  logic [N-1:0] w_sum;

  always_comb begin
    w_sum = i_acc;
    case ({i_q[0], i_qprev})
      2'b10:   w_sum = i_acc - i_m;
      2'b01:   w_sum = i_acc + i_m;
      default: w_sum = i_acc;
    endcase
  end

  assign o_acc   = {w_sum[N-1], w_sum[N-1:1]};
  assign o_q     = {w_sum[0], i_q[N-1:1]};
  assign o_qprev = i_q[0];
endmodule

// File: rtl/seq_mult_param.sv
// Sequential signed/unsigned multiplier: one Booth step per cycle on WIDTH+1-bit operands.
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic             clk,
  input logic             reset_n,
  seq_mult_param_if.slave bus
);
  localparam int N  = WIDTH + 1;
  localparam int CW = cnt_w(WIDTH);

  state_t          r_state, w_next;
  logic [N-1:0]    r_acc, r_q, r_m;
  logic            r_qprev;
  logic [CW-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_out;

  logic [N-1:0]    w_acc_n, w_q_n;
  logic            w_qprev_n;
  logic            w_last, w_cap;

  assign w_last = (r_cnt == CW'(WIDTH));
  assign w_cap  = bus.start && (r_state != RUN);

  booth_step #(.N(N)) u_step (
    .i_acc  (r_acc),
    .i_q    (r_q),
    .i_m    (r_m),
    .i_qprev(r_qprev),
    .o_acc  (w_acc_n),
    .o_q    (w_q_n),
    .o_qprev(w_qprev_n)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    w_next = bus.start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Extension to WIDTH+1 bits lets one signed Booth datapath serve both modes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc   <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_qprev <= 1'b0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else if (w_cap) begin
      r_acc   <= '0;
      r_qprev <= 1'b0;
      r_cnt   <= '0;
      r_m     <= bus.mode_signed ? {bus.m[WIDTH-1], bus.m} : {1'b0, bus.m};
      r_q     <= bus.mode_signed ? {bus.q[WIDTH-1], bus.q} : {1'b0, bus.q};
    end else if (r_state == RUN) begin
      r_acc   <= w_acc_n;
      r_q     <= w_q_n;
      r_qprev <= w_qprev_n;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) r_out <= {w_acc_n[WIDTH-2:0], w_q_n};
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.out  = r_out;
endmodule

// File: tb/tb_seq_mult_param.sv
// Randomized and directed checks of seq_mult_param at WIDTH=4 and WIDTH=8.
module tb_seq_mult_param;
  import seq_mult_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_mult_param_if #(.WIDTH(4)) if4 ();
  seq_mult_param_if #(.WIDTH(8)) if8 ();

  seq_mult_param #(.WIDTH(4)) dut4 (.clk(clk), .reset_n(rst_n), .bus(if4));
  seq_mult_param #(.WIDTH(8)) dut8 (.clk(clk), .reset_n(rst_n), .bus(if8));

  // Reference: integer product of the interpreted operands, reduced mod 2^(2w).
  function automatic longint unsigned ref_mul(input bit md, input int w,
                                              input longint unsigned a, input longint unsigned b);
    longint sa, sb, p;
    longint unsigned mask;
    mask = (64'd1 << (2 * w)) - 64'd1;
    sa = longint'(a);
    sb = longint'(b);
    if (md && a[w-1]) sa = sa - (longint'(1) << w);
    if (md && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return longint'(p) & mask;
  endfunction

  // Issue one op on the WIDTH=4 instance; operands are scrambled right after capture.
  task automatic run4(input bit md, input logic [3:0] a, input logic [3:0] b,
                      output logic [7:0] o, output int lat, output int nb,
                      output bit stable, output bit bd, output bit d2);
    logic [7:0] prev;
    @(negedge clk);
    prev = if4.out;
    if4.start = 1'b1; if4.mode_signed = md; if4.m = a; if4.q = b;
    @(posedge clk); #1;
    if4.start = 1'b0;
    if4.m = 4'($urandom); if4.q = 4'($urandom); if4.mode_signed = 1'($urandom);
    lat = 0; nb = 0; stable = 1'b1; bd = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (if4.busy) nb++;
      if (if4.out !== prev) stable = 1'b0;
      @(posedge clk); #1;
      if (if4.done) begin lat = i; break; end
    end
    o  = if4.out;
    bd = if4.busy;
    @(posedge clk); #1;
    d2 = if4.done;
  endtask

  task automatic run8(input bit md, input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] o, output int lat);
    @(negedge clk);
    if8.start = 1'b1; if8.mode_signed = md; if8.m = a; if8.q = b;
    @(posedge clk); #1;
    if8.start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      if8.m = 8'($urandom); if8.q = 8'($urandom); if8.mode_signed = 1'($urandom);
      if8.start = (i < 5) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      if (if8.done) begin lat = i; break; end
    end
    if8.start = 1'b0;
    o = if8.out;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++; if (if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.out !== 8'h00) begin
      errors++; $display("FAIL reset_w4: busy=%b done=%b out=%h exp 0/0/00", if4.busy, if4.done, if4.out);
    end
    checks++; if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.out !== 16'h0000) begin
      errors++; $display("FAIL reset_w8: busy=%b done=%b out=%h exp 0/0/0000", if8.busy, if8.done, if8.out);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (if4.busy !== 1'b0 || if4.done !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b done=%b exp 0/0", if4.busy, if4.done);
    end
  endtask

  task automatic test_directed;
    bit         md [6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] va [6]  = '{4'hB, 4'hB, 4'h3, 4'h3, 4'h8, 4'hF};
    logic [3:0] vb [6]  = '{4'hD, 4'hD, 4'h8, 4'h8, 4'h8, 4'hF};
    logic [7:0] ve [6]  = '{8'h8F, 8'h0F, 8'h18, 8'hE8, 8'h40, 8'hE1};
    logic [7:0] o; int lat, nb; bit st, bd, d2;
    for (int k = 0; k < 6; k++) begin
      run4(md[k], va[k], vb[k], o, lat, nb, st, bd, d2);
      checks++; if (o !== ve[k]) begin
        errors++; $display("FAIL dir_out[%0d]: out=%h exp %h", k, o, ve[k]);
      end
      checks++; if (lat != 5 || nb != 5) begin
        errors++; $display("FAIL dir_timing[%0d]: done_at=%0d busy_cycles=%0d exp 5/5", k, lat, nb);
      end
      checks++; if (!st || bd || d2) begin
        errors++; $display("FAIL dir_flags[%0d]: out_stable=%b busy_at_done=%b done_next=%b exp 1/0/0", k, st, bd, d2);
      end
    end
    run4(1'b1, 4'h0, 4'hF, o, lat, nb, st, bd, d2);
    checks++; if (o !== 8'h00) begin
      errors++; $display("FAIL dir_zero: out=%h exp 00", o);
    end
  endtask

  task automatic test_random4;
    logic [7:0] o, e; logic [3:0] a, b; bit md; int lat, nb; bit st, bd, d2;
    for (int k = 0; k < 24; k++) begin
      a = 4'($urandom); b = 4'($urandom); md = 1'($urandom);
      e = 8'(ref_mul(md, 4, 64'(a), 64'(b)));
      run4(md, a, b, o, lat, nb, st, bd, d2);
      checks++; if (o !== e || lat != 5) begin
        errors++; $display("FAIL rand4[%0d]: md=%b %h*%h out=%h lat=%0d exp %h lat 5", k, md, a, b, o, lat, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    int t1, t2; logic [7:0] o1, o2;
    @(negedge clk);
    if4.start = 1'b1; if4.mode_signed = 1'b0; if4.m = 4'h3; if4.q = 4'h8;
    @(posedge clk); #1;
    if4.mode_signed = 1'b1;  // next operands, presented while start stays high
    t1 = 0; t2 = 0; o1 = '0; o2 = '0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (if4.done) begin
        if (t1 == 0) begin t1 = i; o1 = if4.out; end
        else begin t2 = i; o2 = if4.out; break; end
      end
    end
    if4.start = 1'b0;
    repeat (2) @(posedge clk);
    checks++; if (t1 != 5 || o1 !== 8'h18) begin
      errors++; $display("FAIL b2b_first: done_at=%0d out=%h exp 5 18", t1, o1);
    end
    checks++; if (t2 - t1 != 6 || o2 !== 8'hE8) begin
      errors++; $display("FAIL b2b_second: gap=%0d out=%h exp 6 E8", t2 - t1, o2);
    end
  endtask

  task automatic test_reset_abort;
    logic [7:0] o; int lat, nb; bit st, bd, d2, saw;
    run4(1'b0, 4'h5, 4'h7, o, lat, nb, st, bd, d2);
    checks++; if (o !== 8'h23) begin
      errors++; $display("FAIL pre_abort: out=%h exp 23", o);
    end
    @(negedge clk);
    if4.start = 1'b1; if4.mode_signed = 1'b0; if4.m = 4'h9; if4.q = 4'h9;
    @(posedge clk); #1;
    if4.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.out !== 8'h00) begin
      errors++; $display("FAIL abort_reset: busy=%b done=%b out=%h exp 0/0/00", if4.busy, if4.done, if4.out);
    end
    #1 rst_n = 1'b1;
    saw = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (if4.done || if4.busy) saw = 1'b1; end
    checks++; if (saw) begin
      errors++; $display("FAIL abort_no_done: activity seen after abort=%b exp 0", saw);
    end
    run4(1'b0, 4'h2, 4'h3, o, lat, nb, st, bd, d2);
    checks++; if (o !== 8'h06 || lat != 5) begin
      errors++; $display("FAIL post_abort: out=%h lat=%0d exp 06 5", o, lat);
    end
  endtask

  task automatic test_w8;
    logic [15:0] o, e; logic [7:0] a, b; bit md; int lat;
    run8(1'b1, 8'h80, 8'h80, o, lat);
    checks++; if (o !== 16'h4000 || lat != 9) begin
      errors++; $display("FAIL w8_minneg: out=%h lat=%0d exp 4000 9", o, lat);
    end
    run8(1'b0, 8'hFF, 8'hFF, o, lat);
    checks++; if (o !== 16'hFE01 || lat != 9) begin
      errors++; $display("FAIL w8_allones: out=%h lat=%0d exp FE01 9", o, lat);
    end
    for (int k = 0; k < 12; k++) begin
      a = 8'($urandom); b = 8'($urandom); md = 1'($urandom);
      e = 16'(ref_mul(md, 8, 64'(a), 64'(b)));
      run8(md, a, b, o, lat);
      checks++; if (o !== e || lat != 9) begin
        errors++; $display("FAIL rand8[%0d]: md=%b %h*%h out=%h lat=%0d exp %h lat 9", k, md, a, b, o, lat, e);
      end
    end
  endtask

  initial begin
    if4.start = 1'b0; if4.mode_signed = 1'b0; if4.m = '0; if4.q = '0;
    if8.start = 1'b0; if8.mode_signed = 1'b0; if8.m = '0; if8.q = '0;
    test_reset();
    test_directed();
    test_random4();
    test_back_to_back();
    test_reset_abort();
    test_w8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_mult_param.md
SEQ_MULT_PARAM -- requirements
Module: seq_mult_param

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request; sampled on rising edge of clk.
REQ-006 mode_signed  input  1  operation type: 1 = two's-complement, 0 = unsigned; captured with start.
REQ-007 m  input  WIDTH  multiplicand; captured with start.
REQ-008 q  input  WIDTH  multiplier; captured with start.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse; out is valid.
REQ-011 out  output  2*WIDTH  product.

Function
REQ-012 The block SHALL use a state machine with states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, start=1 at a clock edge SHALL capture m, q and mode_signed, clear the accumulator and iteration counter, and enter RUN.
REQ-014 Captured operands SHALL be extended to WIDTH+1 bits:
- sign-extended when mode_signed=1;
- zero-extended when mode_signed=0.
REQ-015 Each RUN cycle SHALL perform one radix-2 Booth step on the extended operands:
- examine q[0] and q_prev;
- 10 -> subtract m; 01 -> add m; 00/11 -> no change;
- then arithmetic right shift of {acc, q, q_prev}.
REQ-016 RUN SHALL last exactly WIDTH+1 cycles. On the last RUN edge the block SHALL:
- load the low 2*WIDTH bits of the result into out;
- assert done;
- enter DONE.
REQ-017 Latency: done SHALL be high in the (WIDTH+1)-th cycle after the capturing edge. For WIDTH=4, done rises 5 edges after start is sampled.
REQ-018 done SHALL be high for exactly one cycle, in state DONE only.
REQ-019 DONE SHALL return to IDLE on the next edge unless start=1. With start=1 it SHALL capture the new operands and enter RUN (back-to-back operation, no idle bubble).
REQ-020 start SHALL be ignored while in RUN. The operation in flight and its captured operands SHALL NOT change.
REQ-021 m, q and mode_signed SHALL have no effect on the operation except at the capturing edge.
REQ-022 out SHALL hold the last product until the next done. It SHALL NOT show intermediate values.
REQ-023 Products SHALL be exact modulo 2^(2*WIDTH), with no overflow, including:
- the most-negative x most-negative case (signed);
- the all-ones x all-ones case (unsigned).
REQ-024 busy SHALL equal (state == RUN).

Reset
REQ-025 reset_n=0 SHALL immediately, independent of clk:
- force IDLE;
- set busy=0, done=0, out=0;
- clear the accumulator, counter and captured operands.
REQ-026 Reset asserted mid-RUN SHALL abort the operation without producing done.
REQ-027 After reset_n rises, the first start SHALL behave as in REQ-013.

Structure
REQ-028 Package seq_mult_pkg SHALL hold:
- the state type (IDLE, RUN, DONE);
- the default WIDTH constant;
- a counter-width function ceil(log2(WIDTH+2)).
REQ-029 One sub-module booth_step, purely combinational and parametrised by WIDTH+1, SHALL implement the add/subtract/no-op and the arithmetic shift. The controller, counter and registers SHALL stay in seq_mult_param.
REQ-030 The RTL SHALL contain no multiply operator.

Verification
REQ-031 WIDTH=4, mode 0, m=1011, q=1101, start one cycle:
- busy high for 5 cycles;
- done pulse with out=0x8F (11*13).
REQ-032 WIDTH=4, mode 1, same operands -> out=0x0F (-5 * -3 = 15).
REQ-033 WIDTH=4, m=0011, q=1000:
- mode 0 -> out=0x18;
- mode 1 -> out=0xE8 (-24).
Back-to-back runs with start held through DONE -> second done exactly 6 cycles after the first.
REQ-034 WIDTH=4 boundary operands:
- mode 1, m=q=1000 -> out=0x40;
- mode 0, m=q=1111 -> out=0xE1;
- mode 1, m=0000, q=1111 -> out=0x00.
REQ-035 Start a run, then pulse reset_n low in the 3rd RUN cycle:
- out=0, busy=0 immediately;
- no done;
- next start with m=0010, q=0011 -> out=0x06.
REQ-036 WIDTH=8, mode 1, m=q=0x80 -> out=0x4000 after 9 RUN cycles. Change m and q while busy -> result unchanged.
